rd_dma_sched: RTL and testbench

- Round-robin scheduler that shares the single AXI-Full read engine (the axi_mst read path) between N_REQ on-chip requesters: weight loaders for the conv units, activation loader and instruction fetch.
- Latches the winning request and drives the engine's RSTART/RADDR/RNBURST registers, then tracks RIDLE and the AXIS beat count.
- Reports per-requester completion or error, and emits a one-hot owner select that steers the read AXIS stream to the data consumer (e.g. data_writer).

---
 rtl/rd_dma_sched_pkg.sv | 48 ++++
 rtl/rd_dma_sched_rr_arbiter.sv | 47 ++++
 rtl/rd_dma_sched.sv | 192 +++++++++++++++++++
 tb/tb_rd_dma_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_dma_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_dma_sched_pkg
// Description : Shared types and helpers for the read-DMA scheduler.
//               Holds the FSM state encoding, default widths, and the
//               round-robin "first set bit at or after pointer" helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_dma_sched_pkg;

    localparam int c_cnt_w           = 32;
    localparam int c_beats_per_burst = 16;
    // The arbiter helper works on a fixed 8-wide vector; smaller requester
    // counts are zero-extended into it.
    localparam int c_max_req         = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Returns {found, index} of the first set bit of valid[n-1:0] searching
    // upward from ptr and wrapping at n. ptr must be below n.
    function automatic logic [3:0] rr_first_from(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input logic [3:0] n
    );
        logic [3:0] w_res;
        logic [3:0] w_idx;
        w_res = 4'd0;
        for (int i = 0; i < c_max_req; i++) begin
            w_idx = {1'b0, ptr} + 4'(i);
            if (w_idx >= n) begin
                w_idx = w_idx - n;
            end
            if ((4'(i) < n) && !w_res[3] && valid[w_idx[2:0]]) begin
                w_res = {1'b1, w_idx[2:0]};
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_dma_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rd_dma_sched_rr_arbiter
// Description : Round-robin arbiter. Grant is combinational from the valid
//               vector and the registered pointer; the pointer advances to
//               one past the winner when the grant is taken.
// Ports       : clk, rstn       - clock, async active-low reset
//               i_valid [N_REQ] - pending requests
//               i_take          - grant is consumed this cycle
//               o_grant_oh [N_REQ] - one-hot winner (0 when nothing valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rd_dma_sched_rr_arbiter
    import rd_dma_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_take,
    output logic [N_REQ-1:0] o_grant_oh
);

    logic [2:0] r_ptr;
    logic [7:0] w_valid8;
    logic [3:0] w_pick;

    assign w_valid8 = 8'(i_valid);
    assign w_pick   = rr_first_from(w_valid8, r_ptr, 4'(N_REQ));

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_oh
            assign o_grant_oh[gi] = w_pick[3] && (w_pick[2:0] == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= 3'd0;
        end else if (i_take && w_pick[3]) begin
            r_ptr <= (w_pick[2:0] == 3'(N_REQ - 1)) ? 3'd0 : (w_pick[2:0] + 3'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : rd_dma_sched
// Description : Shares one AXI read engine between N_REQ requesters.
//               Grants round-robin, drives the engine start/address/burst
//               registers, watches RIDLE and counts stream beats, then pulses
//               per-requester done (and err on timeout or beat mismatch).
// Ports       : clk, rstn                  - clock, async active-low reset
//               req_valid/addr/nburst      - requester inputs (packed slices)
//               req_ready/done/err         - one-hot per-requester pulses
//               owner_sel                  - one-hot stream owner, 0 when idle
//               RSTART_REG/RADDR_REG/RNBURST_REG - engine controls
//               RIDLE_REG                  - engine idle status
//               axis_beat                  - read-stream handshake
//               busy                       - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module rd_dma_sched
    import rd_dma_sched_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int BEATS_PER_BURST = c_beats_per_burst,
    parameter int TIMEOUT         = 1024,
    parameter int CNT_W           = c_cnt_w
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CNT_W-1:0] req_addr,
    input  logic [N_REQ*CNT_W-1:0] req_nburst,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       req_done,
    output logic [N_REQ-1:0]       req_err,
    output logic [N_REQ-1:0]       owner_sel,
    output logic                   RSTART_REG,
    output logic [31:0]            RADDR_REG,
    output logic [31:0]            RNBURST_REG,
    input  logic                   RIDLE_REG,
    input  logic                   axis_beat,
    output logic                   busy
);

    state_t            r_state;
    state_t            w_next;
    logic [N_REQ-1:0]  r_owner;
    logic [N_REQ-1:0]  w_grant_oh;
    logic [CNT_W-1:0]  r_addr;
    logic [CNT_W-1:0]  r_nburst;
    logic [CNT_W-1:0]  r_beats;
    logic [CNT_W-1:0]  r_wdog;
    logic              r_err;
    logic [CNT_W-1:0]  w_sel_addr;
    logic [CNT_W-1:0]  w_sel_nburst;
    logic [CNT_W-1:0]  w_beats_final;
    logic [CNT_W-1:0]  w_expect;
    logic              w_take;
    logic              w_wdog_expired;

    // Gating with rstn keeps req_ready low while reset is held, since the
    // grant path is otherwise purely combinational from the inputs.
    assign w_take = rstn && (r_state == ST_IDLE) && RIDLE_REG && (|req_valid);

    rd_dma_sched_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (req_valid),
        .i_take     (w_take),
        .o_grant_oh (w_grant_oh)
    );

    always_comb begin
        w_sel_addr   = '0;
        w_sel_nburst = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_addr   = w_sel_addr   | req_addr[i*CNT_W +: CNT_W];
                w_sel_nburst = w_sel_nburst | req_nburst[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_wdog_expired = (r_wdog == CNT_W'(TIMEOUT - 1));
    // A beat coincident with the final RIDLE edge lands in DRAIN and is
    // folded in here before the comparison.
    assign w_beats_final  = r_beats + CNT_W'(axis_beat);
    assign w_expect       = r_nburst * CNT_W'(BEATS_PER_BURST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = (w_sel_nburst == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                if (!RIDLE_REG) begin
                    w_next = ST_RUN;
                end else if (w_wdog_expired) begin
                    w_next = ST_DONE;
                end
            end
            ST_RUN: begin
                if (RIDLE_REG) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner  <= '0;
            r_addr   <= '0;
            r_nburst <= '0;
            r_beats  <= '0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner  <= w_grant_oh;
                        r_addr   <= w_sel_addr;
                        r_nburst <= w_sel_nburst;
                        r_beats  <= '0;
                        r_wdog   <= '0;
                        r_err    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (RIDLE_REG) begin
                        if (w_wdog_expired) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (axis_beat) begin
                        r_beats <= r_beats + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_beats <= w_beats_final;
                    if (w_beats_final != w_expect) begin
                        r_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_owner  <= '0;
                    r_addr   <= '0;
                    r_nburst <= '0;
                    r_beats  <= '0;
                    r_wdog   <= '0;
                    r_err    <= 1'b0;
                end
                default: begin
                    r_owner <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- outputs
    assign req_ready   = w_take ? w_grant_oh : '0;
    assign req_done    = (r_state == ST_DONE) ? r_owner : '0;
    assign req_err     = ((r_state == ST_DONE) && r_err) ? r_owner : '0;
    assign owner_sel   = r_owner;
    assign RSTART_REG  = (r_state == ST_START);
    assign RADDR_REG   = 32'(r_addr);
    assign RNBURST_REG = 32'(r_nburst);
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rd_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_dma_sched
// Description : Self-checking bench for rd_dma_sched. A scripted read-engine
//               model drives RIDLE/beats per transaction; expected pulses,
//               grant order and error flags come from a round-robin model
//               and burst arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_dma_sched;

    localparam int c_n       = 4;
    localparam int c_w       = 32;
    localparam int c_timeout = 1024;
    localparam int c_bpb     = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [c_n-1:0]    req_valid;
    logic [c_n*c_w-1:0] req_addr;
    logic [c_n*c_w-1:0] req_nburst;
    logic [c_n-1:0]    req_ready;
    logic [c_n-1:0]    req_done;
    logic [c_n-1:0]    req_err;
    logic [c_n-1:0]    owner_sel;
    logic              RSTART_REG;
    logic [31:0]       RADDR_REG;
    logic [31:0]       RNBURST_REG;
    logic              RIDLE_REG;
    logic              axis_beat;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int ptr      = 0;

    always #5 clk = ~clk;

    rd_dma_sched #(
        .N_REQ           (c_n),
        .BEATS_PER_BURST (c_bpb),
        .TIMEOUT         (c_timeout),
        .CNT_W           (c_w)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_nburst  (req_nburst),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .req_err     (req_err),
        .owner_sel   (owner_sel),
        .RSTART_REG  (RSTART_REG),
        .RADDR_REG   (RADDR_REG),
        .RNBURST_REG (RNBURST_REG),
        .RIDLE_REG   (RIDLE_REG),
        .axis_beat   (axis_beat),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] base;
        logic [31:0] nb;
        int          lat;
        int          run;
        int          beats;
        int          drain;
        bit          tmo;
        int          exp_g;
        bit          exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first valid requester at or after pointer.
    function automatic int rr_model(input logic [3:0] v, input int p);
        for (int k = 0; k < c_n; k++) begin
            if (v[(p + k) % c_n]) return (p + k) % c_n;
        end
        return -1;
    endfunction

    task automatic drive_slices(input logic [31:0] base, input logic [31:0] nb);
        for (int i = 0; i < c_n; i++) begin
            req_addr[i*c_w +: c_w]   = base + 32'(i) * 32'h100;
            req_nburst[i*c_w +: c_w] = nb;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"},   32'(req_ready),  32'd0);
        check({tag, " done"},    32'(req_done),   32'd0);
        check({tag, " err"},     32'(req_err),    32'd0);
        check({tag, " owner"},   32'(owner_sel),  32'd0);
        check({tag, " rstart"},  32'(RSTART_REG), 32'd0);
        check({tag, " raddr"},   RADDR_REG,       32'd0);
        check({tag, " rnburst"}, RNBURST_REG,     32'd0);
        check({tag, " busy"},    32'(busy),       32'd0);
    endtask

    // Requests pending while the engine reports busy must not be granted.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 4'($urandom_range(1, 15));
            RIDLE_REG = 1'b0;
            axis_beat = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("gap ready", 32'(req_ready), 32'd0);
            check("gap busy",  32'(busy),      32'd0);
            check("gap owner", 32'(owner_sel), 32'd0);
            next_cycle();
        end
        req_valid = '0;
    endtask

    // One transaction: grant, START for lat cycles (RIDLE falls in the last),
    // run cycles with beats in the first 'beats' of them, RIDLE rise, DRAIN
    // with an optional late beat, then DONE.
    task automatic run_txn(input logic [3:0] valid, input logic [31:0] base,
                           input logic [31:0] nb, input int lat, input int run,
                           input int beats, input int drain, input bit tmo,
                           input int exp_g, input bit exp_err);
        logic [3:0]  oh;
        logic [31:0] exp_addr;
        int          last;
        oh       = 4'b0001 << exp_g;
        exp_addr = base + 32'(exp_g) * 32'h100;

        req_valid = valid;
        drive_slices(base, nb);
        RIDLE_REG = 1'b1;
        axis_beat = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("grant ready",  32'(req_ready),  32'(oh));
        check("grant busy",   32'(busy),       32'd0);
        check("grant owner",  32'(owner_sel),  32'd0);
        check("grant rstart", 32'(RSTART_REG), 32'd0);
        check("idle rnburst", RNBURST_REG,     32'd0);
        next_cycle();

        // Scramble requester inputs; only the grant cycle may matter.
        req_valid  = 4'($urandom);
        req_addr   = {$urandom, $urandom, $urandom, $urandom};
        req_nburst = {$urandom, $urandom, $urandom, $urandom};
        axis_beat  = 1'($urandom_range(0, 1));

        if (nb == 32'd0) begin
            @(negedge clk);
            check("nb0 done",   32'(req_done),   32'(oh));
            check("nb0 err",    32'(req_err),    32'd0);
            check("nb0 rstart", 32'(RSTART_REG), 32'd0);
            check("nb0 ready",  32'(req_ready),  32'd0);
            next_cycle();
            req_valid = '0;
            return;
        end

        last = tmo ? c_timeout : lat;
        for (int c = 1; c <= last; c++) begin
            RIDLE_REG = tmo ? 1'b1 : (c < lat);
            axis_beat = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("start rstart", 32'(RSTART_REG),  32'd1);
            check("start raddr",  RADDR_REG,        exp_addr);
            check("start nburst", RNBURST_REG,      nb);
            check("start owner",  32'(owner_sel),   32'(oh));
            check("start done",   32'(req_done),    32'd0);
            next_cycle();
        end

        if (!tmo) begin
            for (int c = 1; c <= run; c++) begin
                RIDLE_REG = 1'b0;
                axis_beat = (c <= beats);
                @(negedge clk);
                check("run rstart", 32'(RSTART_REG), 32'd0);
                check("run owner",  32'(owner_sel),  32'(oh));
                check("run done",   32'(req_done),   32'd0);
                next_cycle();
            end
            RIDLE_REG = 1'b1;
            axis_beat = 1'b0;
            @(negedge clk);
            check("idle-edge done", 32'(req_done), 32'd0);
            next_cycle();
            axis_beat = 1'(drain);
            @(negedge clk);
            check("drain done", 32'(req_done), 32'd0);
            check("drain busy", 32'(busy),     32'd1);
            next_cycle();
        end

        axis_beat = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done pulse",  32'(req_done),   32'(oh));
        check("done err",    32'(req_err),    exp_err ? 32'(oh) : 32'd0);
        check("done owner",  32'(owner_sel),  32'(oh));
        check("done rstart", 32'(RSTART_REG), 32'd0);
        next_cycle();
        req_valid = '0;
        axis_beat = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int nb;
        int lat;
        int tot;
        int dr;
        int bt;
        int rn;
        int v;
        logic [3:0] vv;

        vecs[0]  = '{4'b1111, 32'h2000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 0, 1'b0};
        vecs[1]  = '{4'b1111, 32'h2000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 1, 1'b0};
        vecs[2]  = '{4'b1111, 32'h2000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 2, 1'b0};
        vecs[3]  = '{4'b1111, 32'h2000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 3, 1'b0};
        vecs[4]  = '{4'b1111, 32'h2000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 0, 1'b0};
        vecs[5]  = '{4'b0001, 32'h1000_0000, 32'd2, 3, 32, 32, 0, 1'b0, 0, 1'b0};
        vecs[6]  = '{4'b0100, 32'h3000_0000, 32'd0, 1, 0,  0,  0, 1'b0, 2, 1'b0};
        vecs[7]  = '{4'b0010, 32'h4000_0000, 32'd2, 2, 33, 31, 0, 1'b0, 1, 1'b1};
        vecs[8]  = '{4'b1000, 32'h5000_0000, 32'd1, 1, 16, 15, 1, 1'b0, 3, 1'b0};
        vecs[9]  = '{4'b1010, 32'h6000_0000, 32'd3, 4, 50, 48, 0, 1'b0, 1, 1'b0};
        vecs[10] = '{4'b0101, 32'h7000_0000, 32'd1, 1, 17, 17, 0, 1'b0, 2, 1'b1};
        vecs[11] = '{4'b0001, 32'h8000_0000, 32'd1, 1, 0,  0,  0, 1'b1, 0, 1'b1};
        vecs[12] = '{4'b1111, 32'h9000_0000, 32'd1, 1, 16, 16, 0, 1'b0, 1, 1'b0};

        // Reset: requests pending with engine idle must still see no pulses.
        rstn       = 1'b0;
        req_valid  = 4'b1111;
        req_addr   = '0;
        req_nburst = '0;
        RIDLE_REG  = 1'b1;
        axis_beat  = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        req_valid = '0;
        axis_beat = 1'b0;
        ptr       = 0;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].valid, vecs[i].base, vecs[i].nb, vecs[i].lat,
                    vecs[i].run, vecs[i].beats, vecs[i].drain, vecs[i].tmo,
                    vecs[i].exp_g, vecs[i].exp_err);
            ptr = (vecs[i].exp_g + 1) % c_n;
            if (i % 3 == 2) gap(1);
        end

        for (int t = 0; t < 30; t++) begin
            vv  = 4'($urandom_range(1, 15));
            g   = rr_model(vv, ptr);
            nb  = $urandom_range(0, 3);
            lat = $urandom_range(1, 4);
            v   = $urandom_range(0, 3);
            tot = nb * c_bpb + ((v == 0) ? -1 : ((v == 3) ? 1 : 0));
            if (tot < 0) tot = 0;
            dr  = (tot > 0) ? $urandom_range(0, 1) : 0;
            bt  = tot - dr;
            rn  = bt + $urandom_range(0, 2);
            gap($urandom_range(0, 2));
            run_txn(vv, $urandom, 32'(nb), lat, rn, bt, dr, 1'b0, g,
                    (tot != nb * c_bpb));
            ptr = (g + 1) % c_n;
        end

        // Reset asserted mid-RUN after requester 0 was granted (pointer = 1).
        req_valid = 4'b0001;
        drive_slices(32'hA000_0000, 32'd1);
        RIDLE_REG = 1'b1;
        @(negedge clk);
        check("pre-reset ready", 32'(req_ready), 32'b0001);
        next_cycle();
        RIDLE_REG = 1'b0;
        next_cycle();
        axis_beat = 1'b1;
        @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async reset");
        req_valid = 4'b1001;
        RIDLE_REG = 1'b1;
        @(negedge clk);
        check("in-reset ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ptr  = 0;
        run_txn(4'b1001, 32'hB000_0000, 32'd1, 1, 16, 16, 0, 1'b0, 0, 1'b0);
        run_txn(4'b1000, 32'hC000_0000, 32'd1, 2, 16, 16, 0, 1'b0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
